id_ex_operand_stage: RTL

ID/EX pipeline register that sits directly upstream of the 32-bit ALU. It captures decoded instruction fields and decodes `alu_op`/`funct` into the 4-bit ALU control code. Each cycle it drives `op1`, `op2` and `alu_control_code` into the ALU, resolving operands through EX/MEM and MEM/WB forwarding. It supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/id_ex_operand_stage_if.sv | 52 +++++
 rtl/id_ex_operand_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode/hazard/forwarding sources and the ID/EX operand stage.
// master: drives decoded fields, hazard controls and forwarding sources.
// slave:  the operand stage itself.
interface id_ex_operand_stage_if;
    // Decode-stage fields and hazard controls
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rd_num;
    logic        reg_write;

    // Forwarding / writeback sources
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;

    // Stage outputs towards the ALU
    logic        out_valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_control_code;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        ctrl_err;

    modport master (
        output in_valid, stall, flush, rs_num, rt_num, rs_data, rt_data, imm, alu_src,
               alu_op, funct, rd_num, reg_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_data,
        input  out_valid, op1, op2, alu_control_code, out_rd, out_reg_write, ctrl_err
    );

    modport slave (
        input  in_valid, stall, flush, rs_num, rt_num, rs_data, rt_data, imm, alu_src,
               alu_op, funct, rd_num, reg_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_data,
        output out_valid, op1, op2, alu_control_code, out_rd, out_reg_write, ctrl_err
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, registers the
// ALU control code, and resolves operands through EX/MEM and MEM/WB forwarding.
module id_ex_operand_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    id_ex_operand_stage_if.slave bus
);

    localparam logic [3:0] CodeNop = 4'b1111;

    // Stored stage contents
    logic        valid_q;
    logic [4:0]  rs_num_q;
    logic [4:0]  rt_num_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_ext_q;
    logic        alu_src_q;
    logic [3:0]  code_q;
    logic [4:0]  rd_q;
    logic        reg_write_q;
    logic        ctrl_err_q;

    // Decode and capture-side helpers
    logic [3:0]  dec_code;
    logic        dec_err;
    logic [31:0] imm_ext;
    logic        memwb_valid;
    logic        cap_rs_hit;
    logic        cap_rt_hit;
    logic        ref_rs_hit;
    logic        ref_rt_hit;

    // Forwarding helpers
    logic        exmem_valid;
    logic        fwd_ex_rs;
    logic        fwd_ex_rt;
    logic        fwd_wb_rs;
    logic        fwd_wb_rt;
    logic [31:0] op1_fwd;
    logic [31:0] op2_fwd;

    // Decode alu_op/funct into the ALU control code; unknown funct flags an error.
    always_comb begin
        dec_code = CodeNop;
        dec_err  = 1'b0;
        unique case (bus.alu_op)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b11: dec_code = 4'b0001;
            2'b10: begin
                case (bus.funct)
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b100000: dec_code = 4'b0010;
                    6'b100010: dec_code = 4'b0110;
                    6'b101010: dec_code = 4'b0111;
                    6'b100111: dec_code = 4'b1001;
                    6'b100110: dec_code = 4'b1101;
                    default:   dec_err  = 1'b1;
                endcase
            end
        endcase
    end

    // ORI zero-extends; everything else sign-extends.
    assign imm_ext = (bus.alu_op == 2'b11) ? {16'h0000, bus.imm}
                                           : {{16{bus.imm[15]}}, bus.imm};

    // MEM/WB match on incoming numbers (capture bypass) and stored numbers (stall refresh).
    assign memwb_valid = bus.memwb_reg_write && (bus.memwb_rd != 5'd0);
    assign cap_rs_hit  = memwb_valid && (bus.memwb_rd == bus.rs_num);
    assign cap_rt_hit  = memwb_valid && (bus.memwb_rd == bus.rt_num);
    assign ref_rs_hit  = memwb_valid && (bus.memwb_rd == rs_num_q);
    assign ref_rt_hit  = memwb_valid && (bus.memwb_rd == rt_num_q);

    // Stage register: reset/flush/bubble clear, stall holds with writeback refresh, else load.
    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.stall && !bus.in_valid)) begin
            valid_q     <= 1'b0;
            rs_num_q    <= 5'd0;
            rt_num_q    <= 5'd0;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm_ext_q   <= 32'd0;
            alu_src_q   <= 1'b0;
            code_q      <= CodeNop;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            ctrl_err_q  <= 1'b0;
        end else if (bus.stall) begin
            if (ref_rs_hit) begin
                rs_data_q <= bus.memwb_data;
            end
            if (ref_rt_hit) begin
                rt_data_q <= bus.memwb_data;
            end
        end else begin
            valid_q     <= 1'b1;
            rs_num_q    <= bus.rs_num;
            rt_num_q    <= bus.rt_num;
            rs_data_q   <= cap_rs_hit ? bus.memwb_data : bus.rs_data;
            rt_data_q   <= cap_rt_hit ? bus.memwb_data : bus.rt_data;
            imm_ext_q   <= imm_ext;
            alu_src_q   <= bus.alu_src;
            code_q      <= dec_code;
            rd_q        <= bus.rd_num;
            reg_write_q <= bus.reg_write && !dec_err;
            ctrl_err_q  <= dec_err;
        end
    end

    // Forwarding match terms; register 0 never forwards.
    assign exmem_valid = FWD_EN && bus.exmem_reg_write && (bus.exmem_rd != 5'd0);
    assign fwd_ex_rs   = exmem_valid && (bus.exmem_rd == rs_num_q);
    assign fwd_ex_rt   = exmem_valid && (bus.exmem_rd == rt_num_q);
    assign fwd_wb_rs   = FWD_EN && ref_rs_hit;
    assign fwd_wb_rt   = FWD_EN && ref_rt_hit;

    // Operand select: EX/MEM beats MEM/WB beats stored data; immediate is never forwarded.
    always_comb begin
        op1_fwd = rs_data_q;
        if (fwd_ex_rs) begin
            op1_fwd = bus.exmem_result;
        end else if (fwd_wb_rs) begin
            op1_fwd = bus.memwb_data;
        end

        op2_fwd = rt_data_q;
        if (alu_src_q) begin
            op2_fwd = imm_ext_q;
        end else if (fwd_ex_rt) begin
            op2_fwd = bus.exmem_result;
        end else if (fwd_wb_rt) begin
            op2_fwd = bus.memwb_data;
        end
    end

    assign bus.out_valid        = valid_q;
    assign bus.op1              = op1_fwd;
    assign bus.op2              = op2_fwd;
    assign bus.alu_control_code = code_q;
    assign bus.out_rd           = rd_q;
    assign bus.out_reg_write    = reg_write_q;
    assign bus.ctrl_err         = ctrl_err_q;

endmodule
